// File: rtl/alarm_ringer.sv
// Alarm comparison and ringing controller: synchronises the 1 Hz tick, matches
// the alarm time, and sequences ringing, snooze, dismiss and auto-timeout.
module alarm_ringer #(
   parameter int RING_TIMEOUT_S = 60,
   parameter int SNOOZE_S       = 300,
   parameter int MAX_SNOOZE     = 3,
   parameter int TONE_DIV       = 50000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sec_clk,
   input  logic        alarm_en,
   input  logic        settime,
   input  logic        dismiss,
   input  logic        snooze,
   input  logic [23:0] cur_digits,
   input  logic [23:0] alm_digits,
   output logic        ringing,
   output logic        snoozing,
   output logic        flash,
   output logic        beep,
   output logic [1:0]  snooze_left
);

   localparam int RW = (RING_TIMEOUT_S > 1) ? $clog2(RING_TIMEOUT_S) : 1;
   localparam int SW = (SNOOZE_S > 1)       ? $clog2(SNOOZE_S)       : 1;
   localparam int TW = (TONE_DIV > 1)       ? $clog2(TONE_DIV)       : 1;

   localparam logic [RW-1:0] RING_LAST = RW'(RING_TIMEOUT_S - 1);
   localparam logic [SW-1:0] SNZ_LAST  = SW'(SNOOZE_S - 1);
   localparam logic [TW-1:0] TONE_LAST = TW'(TONE_DIV - 1);
   localparam logic [1:0]    SNZ_MAX   = 2'(MAX_SNOOZE);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_RINGING,
      S_SNOOZE
   } state_t;

   state_t        state, state_n;
   logic [RW-1:0] ring_cnt, ring_cnt_n;
   logic [SW-1:0] snz_cnt, snz_cnt_n;
   logic [TW-1:0] tone_cnt, tone_cnt_n;
   logic          tone, tone_n;
   logic          flash_q, flash_n;
   logic [1:0]    left_q, left_n;

   logic sync_meta, sync_q, sec_prev;
   logic sec_pulse;
   logic match;

   // sec_clk is asynchronous to clk; two flops before it is used anywhere.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_meta <= 1'b0;
         sync_q    <= 1'b0;
         sec_prev  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make each flop sample the previous
         // stage's old value, which is what turns three lines into a shift chain.
         sync_meta <= sec_clk;
         sync_q    <= sync_meta;
         sec_prev  <= sync_q;
      end
   end

   assign sec_pulse = sync_q & ~sec_prev;
   assign match     = (cur_digits == alm_digits) & alarm_en & ~settime;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         ring_cnt <= '0;
         snz_cnt  <= '0;
         tone_cnt <= '0;
         tone     <= 1'b0;
         flash_q  <= 1'b0;
         left_q   <= 2'd0;
      end else begin
         state    <= state_n;
         ring_cnt <= ring_cnt_n;
         snz_cnt  <= snz_cnt_n;
         tone_cnt <= tone_cnt_n;
         tone     <= tone_n;
         flash_q  <= flash_n;
         left_q   <= left_n;
      end
   end

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      state_n    = state;
      ring_cnt_n = ring_cnt;
      snz_cnt_n  = snz_cnt;
      flash_n    = flash_q;
      left_n     = left_q;

      unique case (state)
         S_IDLE: begin
            flash_n = 1'b0;
            if (alarm_en) state_n = S_ARMED;
         end

         S_ARMED: begin
            flash_n = 1'b0;
            if (!alarm_en) begin
               state_n = S_IDLE;
            end else if (sec_pulse && match) begin
               state_n    = S_RINGING;
               ring_cnt_n = '0;
               left_n     = SNZ_MAX;
               flash_n    = 1'b1;
            end
         end

         // Key pulses outrank the per-second bookkeeping in the same cycle.
         S_RINGING: begin
            if (!alarm_en) begin
               state_n = S_IDLE;
               flash_n = 1'b0;
            end else if (dismiss) begin
               state_n = S_ARMED;
               flash_n = 1'b0;
            end else if (snooze && left_q != 2'd0) begin
               state_n   = S_SNOOZE;
               left_n    = left_q - 2'd1;
               snz_cnt_n = '0;
               flash_n   = 1'b0;
            end else if (sec_pulse) begin
               if (ring_cnt == RING_LAST) begin
                  state_n = S_ARMED;
                  flash_n = 1'b0;
               end else begin
                  ring_cnt_n = ring_cnt + 1'b1;
                  flash_n    = ~flash_q;
               end
            end
         end

         S_SNOOZE: begin
            flash_n = 1'b0;
            if (!alarm_en) begin
               state_n = S_IDLE;
            end else if (dismiss) begin
               state_n = S_ARMED;
            end else if (sec_pulse) begin
               if (snz_cnt == SNZ_LAST) begin
                  state_n    = S_RINGING;
                  ring_cnt_n = '0;
                  flash_n    = 1'b1;
               end else begin
                  snz_cnt_n = snz_cnt + 1'b1;
               end
            end
         end

         default: begin
            state_n = S_IDLE;
            flash_n = 1'b0;
         end
      endcase
   end

   // Tone generator runs only while ringing and restarts from zero each time.
   always_comb begin
      tone_cnt_n = '0;
      tone_n     = 1'b0;
      if (state == S_RINGING) begin
         if (tone_cnt == TONE_LAST) begin
            tone_cnt_n = '0;
            tone_n     = ~tone;
         end else begin
            tone_cnt_n = tone_cnt + 1'b1;
            tone_n     = tone;
         end
      end
   end

   assign ringing     = (state == S_RINGING);
   assign snoozing    = (state == S_SNOOZE);
   assign flash       = flash_q;
   assign snooze_left = left_q;
   assign beep        = tone & ringing & flash_q;

endmodule

// File: tb/tb_alarm_ringer.sv
// Randomised and directed bench for alarm_ringer, checked every cycle against a
// seconds-level behavioural model of the alarm.
module tb_alarm_ringer;

   localparam int RT = 4;
   localparam int SS = 3;
   localparam int MS = 2;
   localparam int TD = 4;
   localparam int HALF_SEC = 20;

   localparam int M_OFF  = 0;
   localparam int M_ARM  = 1;
   localparam int M_RING = 2;
   localparam int M_SNZ  = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        sec_clk;
   logic        alarm_en;
   logic        settime;
   logic        dismiss;
   logic        snooze;
   logic [23:0] cur_digits;
   logic [23:0] alm_digits;
   logic        ringing;
   logic        snoozing;
   logic        flash;
   logic        beep;
   logic [1:0]  snooze_left;

   always #5 clk = ~clk;

   alarm_ringer #(
      .RING_TIMEOUT_S(RT),
      .SNOOZE_S      (SS),
      .MAX_SNOOZE    (MS),
      .TONE_DIV      (TD)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .sec_clk    (sec_clk),
      .alarm_en   (alarm_en),
      .settime    (settime),
      .dismiss    (dismiss),
      .snooze     (snooze),
      .cur_digits (cur_digits),
      .alm_digits (alm_digits),
      .ringing    (ringing),
      .snoozing   (snoozing),
      .flash      (flash),
      .beep       (beep),
      .snooze_left(snooze_left)
   );

   int checks = 0;
   int errors = 0;

   int tsec;
   int asec;
   int phase;
   bit rose;

   // Model: mode, seconds spent in the current mode, snoozes remaining,
   // flash level, clk edges spent ringing, and clk edges sec_clk has been high.
   int m_mode;
   int m_secs;
   int m_left;
   bit m_flash;
   int m_edges;
   int hi_run;

   function automatic logic [23:0] bcd(input int s);
      int h, m, x;
      h = (s / 3600) % 24;
      m = (s / 60) % 60;
      x = s % 60;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode  = M_OFF;
      m_secs  = 0;
      m_left  = 0;
      m_flash = 1'b0;
      m_edges = 0;
      hi_run  = 0;
   endtask

   // One clk edge of the alarm's rules, in terms of seconds and remaining snoozes.
   task automatic model_step();
      bit pulse;
      bit hit;
      pulse   = (hi_run == 2);
      hi_run  = sec_clk ? hi_run + 1 : 0;
      m_edges = (m_mode == M_RING) ? m_edges + 1 : 0;
      hit     = (tsec == asec) && alarm_en && !settime;
      case (m_mode)
         M_OFF: if (alarm_en) m_mode = M_ARM;
         M_ARM: begin
            if (!alarm_en) m_mode = M_OFF;
            else if (pulse && hit) begin
               m_mode = M_RING; m_secs = 0; m_left = MS; m_flash = 1'b1;
            end
         end
         M_RING: begin
            if (!alarm_en) m_mode = M_OFF;
            else if (dismiss) m_mode = M_ARM;
            else if (snooze && m_left > 0) begin
               m_mode = M_SNZ; m_left = m_left - 1; m_secs = 0;
            end else if (pulse) begin
               m_secs = m_secs + 1;
               if (m_secs == RT) m_mode = M_ARM;
               else m_flash = !m_flash;
            end
         end
         default: begin
            if (!alarm_en) m_mode = M_OFF;
            else if (dismiss) m_mode = M_ARM;
            else if (pulse) begin
               m_secs = m_secs + 1;
               if (m_secs == SS) begin
                  m_mode = M_RING; m_secs = 0; m_flash = 1'b1;
               end
            end
         end
      endcase
   endtask

   task automatic compare_all();
      bit e_ring, e_flash;
      e_ring  = (m_mode == M_RING);
      e_flash = e_ring && m_flash;
      check("ringing", ringing, e_ring);
      check("snoozing", snoozing, m_mode == M_SNZ);
      check("flash", flash, e_flash);
      check("beep", beep, e_flash && ((m_edges / TD) % 2 == 1));
      check("snooze_left", snooze_left, m_left);
   endtask

   // Advance one clk: model and compare just after the edge, drive on the falling edge.
   task automatic tick();
      @(posedge clk);
      if (reset) model_reset();
      else model_step();
      #1 compare_all();
      @(negedge clk);
      rose = 1'b0;
      phase++;
      if (phase == HALF_SEC) begin
         phase   = 0;
         sec_clk = ~sec_clk;
         if (sec_clk) begin
            tsec++;
            cur_digits = bcd(tsec);
            rose = 1'b1;
         end
      end
   endtask

   task automatic press(input bit d, input bit s);
      dismiss = d;
      snooze  = s;
      tick();
      dismiss = 1'b0;
      snooze  = 1'b0;
   endtask

   task automatic set_alarm(input int a);
      asec       = a;
      alm_digits = bcd(a);
   endtask

   task automatic ring_at(input int a);
      int n;
      set_alarm(a);
      n = 0;
      while (ringing !== 1'b1 && n < 400) begin
         tick();
         n++;
      end
      check("ring_at", ringing, 1);
   endtask

   task automatic wait_ring(output int rises);
      int n;
      rises = 0;
      n = 0;
      while (ringing !== 1'b1 && n < 400) begin
         tick();
         if (rose) rises++;
         n++;
      end
   endtask

   task automatic async_reset();
      #2 reset = 1'b1;
      model_reset();
      #1;
      check("rst_now_ringing", ringing, 0);
      check("rst_now_snoozing", snoozing, 0);
      check("rst_now_flash", flash, 0);
      check("rst_now_beep", beep, 0);
      check("rst_now_left", snooze_left, 0);
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int rises;
      int drop_sec;
      int n;
      int r;

      reset    = 1'b1;
      sec_clk  = 1'b0;
      alarm_en = 1'b0;
      settime  = 1'b0;
      dismiss  = 1'b0;
      snooze   = 1'b0;
      tsec     = 0;
      phase    = 0;
      rose     = 1'b0;
      cur_digits = bcd(0);
      set_alarm(5);
      model_reset();

      repeat (3) tick();
      reset = 1'b0;
      check("reset_ringing", ringing, 0);
      check("reset_left", snooze_left, 0);
      check("reset_flash", flash, 0);

      // Trigger at 00:00:05, ringing exactly three clk edges after sec_clk rises.
      alarm_en = 1'b1;
      n = 0;
      while (!(rose && tsec == 5) && n < 400) begin
         tick();
         n++;
      end
      check("trigger_reached", tsec, 5);
      tick();
      tick();
      check("trigger_edge2_ringing", ringing, 0);
      tick();
      check("trigger_edge3_ringing", ringing, 1);
      check("trigger_left", snooze_left, 2);
      check("trigger_flash", flash, 1);
      check("trigger_beep_low", beep, 0);
      repeat (4) tick();
      check("trigger_beep_high", beep, 1);

      // Auto-timeout: pulses at 6,7,8 keep it ringing, the one at 9 silences it.
      n = 0;
      while (ringing === 1'b1 && n < 400) begin
         tick();
         n++;
      end
      drop_sec = tsec;
      check("timeout_second", drop_sec, 9);
      check("timeout_flash", flash, 0);

      // Snooze sequence until snoozes are exhausted.
      ring_at(tsec + 2);
      press(1'b0, 1'b1);
      check("snz1_snoozing", snoozing, 1);
      check("snz1_left", snooze_left, 1);
      wait_ring(rises);
      check("snz1_seconds", rises, 3);
      check("snz1_ringing", ringing, 1);
      press(1'b0, 1'b1);
      check("snz2_left", snooze_left, 0);
      wait_ring(rises);
      check("snz2_seconds", rises, 3);
      press(1'b0, 1'b1);
      check("snz3_ignored_ringing", ringing, 1);
      check("snz3_ignored_snoozing", snoozing, 0);

      // Dismiss beats snooze; dismiss out of snooze.
      press(1'b1, 1'b1);
      check("both_keys_ringing", ringing, 0);
      check("both_keys_snoozing", snoozing, 0);
      ring_at(tsec + 2);
      check("rearm_left", snooze_left, 2);
      set_alarm(asec + 100);
      press(1'b0, 1'b1);
      check("snz_again", snoozing, 1);
      press(1'b1, 1'b0);
      check("dismiss_snz_snoozing", snoozing, 0);
      check("dismiss_snz_ringing", ringing, 0);

      // Suppression by settime, then alarm_en dropped while ringing.
      settime = 1'b1;
      set_alarm(tsec + 2);
      repeat (160) tick();
      check("settime_no_ring", ringing, 0);
      settime = 1'b0;
      ring_at(tsec + 2);
      alarm_en = 1'b0;
      tick();
      check("disable_ringing", ringing, 0);
      check("disable_flash", flash, 0);
      check("disable_beep", beep, 0);
      alarm_en = 1'b1;
      tick();

      // Asynchronous reset in the middle of a snooze.
      ring_at(tsec + 2);
      press(1'b0, 1'b1);
      repeat (5) tick();
      async_reset();
      tick();
      check("post_reset_left", snooze_left, 0);
      ring_at(tsec + 2);
      check("post_reset_rearmed_left", snooze_left, 2);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 999);
         if (r < 8) press(1'b1, 1'($urandom_range(0, 1)));
         else if (r < 20) press(1'b0, 1'b1);
         else if (r < 23) begin alarm_en = ~alarm_en; tick(); end
         else if (r < 25) begin settime = ~settime; tick(); end
         else if (r < 40) begin set_alarm(tsec + $urandom_range(0, 3)); tick(); end
         else if (r < 41) async_reset();
         else tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
